// File: rtl/vga_scan_ctrl.sv
// 640x480@60 VGA raster generator: framebuffer read address one pixel ahead, 4:4:4 RGB, active-low syncs.
// Optional checkerboard test pattern is compiled in with `define VGA_TEST_PATTERN_EN.
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [18:0] raddr,
  input  logic [15:0] data,
  input  logic        test_pat,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [18:0] ADDR_MAX  = 19'(H_ACTIVE * V_ACTIVE - 1);

  logic [3:0]  div_q, div_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [18:0] raddr_q, raddr_d;
  logic        hs_q, hs_d, vs_q, vs_d, fd_q, fd_d;
  logic [3:0]  r_q, r_d, g_q, g_d;
  logic        pix_tick, active0, hs0, vs0, h_wrap, v_wrap;
  logic        unused_ok;

  assign unused_ok = ^{test_pat, data[11:8], data[3:0]};

  always_comb begin
    pix_tick = (div_q == DIV_LAST);
    active0  = (h_q < H_ACT) && (v_q < V_ACT);
    hs0      = !((h_q >= HS_START) && (h_q < HS_END));
    vs0      = !((v_q >= VS_START) && (v_q < VS_END));
    h_wrap   = (h_q == H_LAST);
    v_wrap   = (v_q == V_LAST);

    div_d   = pix_tick ? 4'd0 : div_q + 4'd1;
    h_d     = h_q;
    v_d     = v_q;
    raddr_d = raddr_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    r_d     = r_q;
    g_d     = g_q;
    fd_d    = 1'b0;

    if (pix_tick) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      // Saturate at the last active pixel so blanking never shows an out-of-frame address.
      if (h_wrap && v_wrap)                     raddr_d = 19'd0;
      else if (active0 && raddr_q != ADDR_MAX)  raddr_d = raddr_q + 19'd1;
      hs_d = hs0;
      vs_d = vs0;
      r_d  = 4'h0;
      g_d  = 4'h0;
      if (active0) begin
`ifdef VGA_TEST_PATTERN_EN
        if (test_pat) begin
          r_d = (h_q[3] ^ v_q[3]) ? 4'hF : 4'h0;
          g_d = (h_q[3] ^ v_q[3]) ? 4'hB : 4'h0;
        end else begin
          r_d = data[15:12];
          g_d = data[7:4];
        end
`else
        r_d = data[15:12];
        g_d = data[7:4];
`endif
      end
      fd_d = h_wrap && (v_q == V_ACT_END);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      raddr_q <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      fd_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      raddr_q <= raddr_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      fd_q    <= fd_d;
    end
  end

  assign raddr      = raddr_q;
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign vga_r      = r_q;
  assign vga_g      = g_q;
  assign vga_b      = 4'h0;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a shrunken raster, checked every cycle against a position-based model.
module tb_vga_scan_ctrl;

  localparam int D   = 2;
  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HBP = 3;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int NPIX = HA * VA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] raddr;
  logic [15:0] data = 16'h0;
  logic        test_pat;
  logic        vga_hs, vga_vs, frame_done;
  logic [3:0]  vga_r, vga_g, vga_b;

  logic [15:0] mem [NPIX];
  logic        tp_hist [8192];
  int          n;
  int          seg;
  int          n_chk = 0;
  int          n_fail = 0;

  vga_scan_ctrl #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .data(data), .test_pat(test_pat),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read framebuffer: data follows raddr one clock later.
  always @(posedge clk) data <= (raddr < 19'(NPIX)) ? mem[raddr] : 16'h0;

  // Clock edges since reset release, plus test_pat as seen at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else begin
      n <= n + 1;
      tp_hist[(n + 1) % 8192] <= test_pat;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s seg=%0d edge=%0d got=%0h expected=%0h", nm, seg, n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin : cmp
      int p, h, v, cnt, q, hq, vq, eaddr;
      logic [15:0] d;
      logic ehs, evs, efd;
      logic [3:0] er, eg;
      p   = n / D;
      h   = p % HT;
      v   = (p / HT) % VT;
      cnt = (v < VA) ? v * HA + ((h < HA) ? h : HA) : NPIX;
      eaddr = (cnt > NPIX - 1) ? NPIX - 1 : cnt;
      ehs = 1'b1; evs = 1'b1; efd = 1'b0; er = 4'h0; eg = 4'h0;
      if (p > 0) begin
        q   = p - 1;
        hq  = q % HT;
        vq  = (q / HT) % VT;
        ehs = !(hq >= HA + HFP && hq < HA + HFP + HS);
        evs = !(vq >= VA + VFP && vq < VA + VFP + VS);
        efd = (n % D == 0) && (q % (HT * VT) == (VA - 1) * HT + HT - 1);
        if (hq < HA && vq < VA) begin
          d  = mem[vq * HA + hq];
          er = d[15:12];
          eg = d[7:4];
`ifdef VGA_TEST_PATTERN_EN
          if (tp_hist[(D * p) % 8192]) begin
            er = (((hq ^ vq) >> 3) & 1) != 0 ? 4'hF : 4'h0;
            eg = (((hq ^ vq) >> 3) & 1) != 0 ? 4'hB : 4'h0;
          end
`endif
        end
      end
      chk("raddr", 32'(raddr), 32'(eaddr));
      chk("hs", 32'(vga_hs), 32'(ehs));
      chk("vs", 32'(vga_vs), 32'(evs));
      chk("r", 32'(vga_r), 32'(er));
      chk("g", 32'(vga_g), 32'(eg));
      chk("b", 32'(vga_b), 32'd0);
      chk("frame_done", 32'(frame_done), 32'(efd));

      // Hand-computed points that pin the model on this raster.
      case (n)
        37:   chk("lit_hs_before_fall", 32'(vga_hs), 32'd1);
        38:   chk("lit_hs_first_fall", 32'(vga_hs), 32'd0);
        44:   chk("lit_hs_last_low", 32'(vga_hs), 32'd0);
        46:   chk("lit_hs_rise", 32'(vga_hs), 32'd1);
        30:   chk("lit_raddr_end_line0", 32'(raddr), 32'd15);
        50:   chk("lit_raddr_line1", 32'(raddr), 32'd16);
        580:  chk("lit_raddr_max", 32'(raddr), 32'd191);
        600:  begin
                chk("lit_fd_first", 32'(frame_done), 32'd1);
                chk("lit_raddr_vblank", 32'(raddr), 32'd191);
              end
        601:  chk("lit_fd_width", 32'(frame_done), 32'd0);
        700:  chk("lit_vs_before", 32'(vga_vs), 32'd1);
        702:  chk("lit_vs_fall", 32'(vga_vs), 32'd0);
        950:  chk("lit_raddr_wrap", 32'(raddr), 32'd0);
        1550: chk("lit_fd_second", 32'(frame_done), 32'd1);
        default: ;
      endcase
      if (seg == 1 && n == 110) chk("lit_amber_4_2", 32'({vga_r, vga_g, vga_b}), 32'h0FB0);
      if (seg == 1 && n == 112) chk("lit_black_5_2", 32'({vga_r, vga_g, vga_b}), 32'h0000);
      if (seg == 2 && n == 2)   chk("lit_pat_0_0", 32'({vga_r, vga_g, vga_b}), 32'h0000);
      if (seg == 2 && n == 418) chk("lit_pat_8_8", 32'({vga_r, vga_g, vga_b}), 32'h0000);
`ifdef VGA_TEST_PATTERN_EN
      if (seg == 2 && n == 18)  chk("lit_pat_8_0", 32'({vga_r, vga_g, vga_b}), 32'h0FB0);
`else
      if (seg == 2 && n == 18)  chk("lit_pat_8_0", 32'({vga_r, vga_g, vga_b}), 32'h0000);
`endif
    end
  end

  task automatic enter_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_hs", 32'(vga_hs), 32'd1);
    chk("rst_vs", 32'(vga_vs), 32'd1);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
  endtask

  task automatic leave_reset(input int ncyc);
    repeat (ncyc) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic run(input int ncyc, input bit rand_tp);
    repeat (ncyc) begin
      @(negedge clk);
      if (rand_tp) test_pat = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_pat = 1'b0;
    seg = 0;
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
    repeat (5) @(posedge clk);
    #1;
    chk("por_hs", 32'(vga_hs), 32'd1);
    chk("por_vs", 32'(vga_vs), 32'd1);
    chk("por_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    #2 rst_n = 1'b1;
    run(2200, 1'b1);

    enter_reset();
    seg = 1;
    test_pat = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = 16'hFFBF;
    mem[2 * HA + 5] = 16'h0000;
    leave_reset(5);
    run(1000, 1'b0);

    enter_reset();
    seg = 2;
    test_pat = 1'b1;
    for (int i = 0; i < NPIX; i++) mem[i] = 16'h0000;
    leave_reset(5);
    run(450, 1'b0);

    enter_reset();
    seg = 3;
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
    leave_reset(5);
    run(D * (5 * HT + 10), 1'b1);
    enter_reset();
    leave_reset(3);
    run(1000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
